// File: rtl/pc_pkg.sv
// Shared types, default constants and helpers for the program counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int unsigned XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;
  localparam int unsigned INSTR_BYTES_DEFAULT  = 4;

  // Number of PC low bits that must be zero for an aligned target.
  function automatic int unsigned align_bits(input int unsigned instr_bytes);
    return (instr_bytes <= 1) ? 0 : $clog2(instr_bytes);
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational next-PC arbiter: resolves trap, return, halt and write requests
// against the current state. Optional macro PC_MISALIGN_TRAP_EN turns a misaligned
// target write into a trap entry instead of silently aligning it.
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(TRAP_VECTOR_DEFAULT),
  parameter int unsigned     INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  pc_state_t       i_state,
  input  logic            i_pc_write,
  input  logic            i_pc_sel,
  input  logic [XLEN-1:0] i_pc_next,
  input  logic            i_trap_req,
  input  logic            i_trap_ret,
  input  logic            i_halt_req,
  input  logic            i_resume,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_epc,
  output logic [XLEN-1:0] o_pc_next,
  output logic [XLEN-1:0] o_epc_next,
  output pc_state_t       o_state_next,
  output logic            o_misalign_set
);

  localparam int unsigned     ALIGN_BITS = align_bits(INSTR_BYTES);
  // Mask form keeps ALIGN_BITS == 0 legal: the mask is simply all zeros.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] INSTR_INC  = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_target_aligned;
  logic            w_target_misaligned;

  assign w_seq_pc            = i_pc + INSTR_INC;
  assign w_target_aligned    = i_pc_next & ~ALIGN_MASK;
  assign w_target_misaligned = |(i_pc_next & ALIGN_MASK);

  // Next-state/next-PC selection; hold everything unless a request wins.
  always_comb begin
    o_pc_next      = i_pc;
    o_epc_next     = i_epc;
    o_state_next   = i_state;
    o_misalign_set = 1'b0;

    case (i_state)
      BOOT: begin
        o_state_next = RUN;
      end

      RUN: begin
        if (i_trap_req) begin
          o_epc_next = i_pc;
          o_pc_next  = TRAP_VECTOR;
        end else if (i_trap_ret) begin
          o_pc_next = i_epc;
        end else if (i_halt_req) begin
          o_state_next = HALT;
        end else if (i_pc_write && !i_pc_sel) begin
          o_pc_next = w_seq_pc;
        end else if (i_pc_write && i_pc_sel) begin
          if (w_target_misaligned) begin
            o_misalign_set = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            o_epc_next = i_pc;
            o_pc_next  = TRAP_VECTOR;
`else
            o_pc_next  = w_target_aligned;
`endif
          end else begin
            o_pc_next = i_pc_next;
          end
        end
      end

      HALT: begin
        if (i_trap_req) begin
          o_epc_next   = i_pc;
          o_pc_next    = TRAP_VECTOR;
          o_state_next = RUN;
        end else if (i_resume) begin
          o_state_next = RUN;
        end
      end

      // Unused encoding: restart through BOOT.
      default: begin
        o_state_next = BOOT;
      end
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter unit: state, PC, exception PC and sticky misalign registers.
// Next values come from pc_redirect_arb. Optional macro: PC_MISALIGN_TRAP_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEFAULT),
  parameter int unsigned     INSTR_BYTES  = INSTR_BYTES_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_pc_write,
  input  logic            i_pc_sel,
  input  logic [XLEN-1:0] i_pc_next,
  input  logic            i_trap_req,
  input  logic            i_trap_ret,
  input  logic            i_halt_req,
  input  logic            i_resume,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_epc,
  output logic            o_pc_valid,
  output logic            o_halted,
  output logic            o_misalign
);

  pc_state_t       r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic            r_misalign;

  pc_state_t       w_state_next;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_epc_next;
  logic            w_misalign_set;

  pc_redirect_arb #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_arb (
    .i_state        (r_state),
    .i_pc_write     (i_pc_write),
    .i_pc_sel       (i_pc_sel),
    .i_pc_next      (i_pc_next),
    .i_trap_req     (i_trap_req),
    .i_trap_ret     (i_trap_ret),
    .i_halt_req     (i_halt_req),
    .i_resume       (i_resume),
    .i_pc           (r_pc),
    .i_epc          (r_epc),
    .o_pc_next      (w_pc_next),
    .o_epc_next     (w_epc_next),
    .o_state_next   (w_state_next),
    .o_misalign_set (w_misalign_set)
  );

  // State and PC registers; synchronous reset overrides every request.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VECTOR;
      r_epc      <= RESET_VECTOR;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_epc      <= w_epc_next;
      r_misalign <= r_misalign | w_misalign_set;
    end
  end

  assign o_pc       = r_pc;
  assign o_epc      = r_epc;
  assign o_misalign = r_misalign;
  assign o_pc_valid = (r_state == RUN);
  assign o_halted   = (r_state == HALT);

endmodule
